// File: rtl/game_flow_ctrl_if.sv
// rtl/game_flow_ctrl_if.sv - player/frame/hit inputs and flow pulses of game_flow_ctrl
//
// Purpose: groups the game-flow controller's stimulus inputs and its
// screen-selection / HUD outputs so they travel as one bundle.
// Signals:
//   btn_in     raw asynchronous player button, active-high
//   vsync_in   game-path vsync, clk40 domain
//   hit        one-cycle strobe: player lost a life
//   start      one-cycle pulse: leave START
//   restart    one-cycle pulse: leave END
//   end_game   one-cycle pulse: leave GAME
//   phase      current phase (START=00, GAME=01, END=11)
//   lives_left remaining lives
//   time_left  remaining frames in the round
// Modports: master drives the inputs and observes the outputs,
//           slave is the controller itself.

interface game_flow_ctrl_if;
  logic        btn_in;
  logic        vsync_in;
  logic        hit;
  logic        start;
  logic        restart;
  logic        end_game;
  logic [1:0]  phase;
  logic [1:0]  lives_left;
  logic [10:0] time_left;

  modport master (
    output btn_in, vsync_in, hit,
    input  start, restart, end_game, phase, lives_left, time_left
  );

  modport slave (
    input  btn_in, vsync_in, hit,
    output start, restart, end_game, phase, lives_left, time_left
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - START/GAME/END flow controller feeding the screen multiplexer
//
// Purpose: debounces the player button and turns it, the game-frame vsync and
// the hit strobe into one-cycle start/restart/end_game pulses, while tracking
// the phase itself and publishing remaining lives and time for the HUD.
// Optional feature: define GAME_TIMER_EN to build the frame-tick round timer;
// without it time_left is held at 0, vsync_in is ignored and only lives end a
// round.
// Ports:
//   clk40  system clock, 40 MHz
//   rst_n  synchronous active-low reset
//   gf     game_flow_ctrl_if.slave (btn_in, vsync_in, hit in;
//          start, restart, end_game, phase, lives_left, time_left out)
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a button level (>= 2)
//   GAME_FRAMES      frames per round (1..2047)
//   LIVES            lives per round (1..3)

module game_flow_ctrl #(
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int GAME_FRAMES     = 1800,
  parameter int LIVES           = 3
) (
  input  logic             clk40,
  input  logic             rst_n,
  game_flow_ctrl_if.slave  gf
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    PH_START = 2'b00,
    PH_GAME  = 2'b01,
    PH_END   = 2'b11
  } phase_t;

  // ---------------------------------------------------------------------
  // Button path: 2-flop synchronizer, debouncer, rising-edge detect
  // ---------------------------------------------------------------------
  logic             btn_meta;
  logic             btn_sync;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] deb_cnt;
  logic             press;

  always_ff @(posedge clk40) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_meta <= gf.btn_in;
      btn_sync <= btn_meta;
      stable_d <= stable;
      // Any return to the accepted level restarts the qualification window.
      if (btn_sync == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
        stable  <= btn_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  // Only the press edge matters; releases are silent.
  assign press = stable & ~stable_d;

  // ---------------------------------------------------------------------
  // Frame tick: registered vsync rising edge
  // ---------------------------------------------------------------------
`ifdef GAME_TIMER_EN
  logic vsync_d;
  logic tick_q;

  always_ff @(posedge clk40) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      vsync_d <= gf.vsync_in;
      tick_q  <= gf.vsync_in & ~vsync_d;
    end
  end
`else
  logic vsync_unused;
  assign vsync_unused = gf.vsync_in;
`endif

  // ---------------------------------------------------------------------
  // Phase FSM with registered pulses and counters
  // ---------------------------------------------------------------------
  phase_t      phase_q, phase_d;
  logic        start_q, start_d;
  logic        restart_q, restart_d;
  logic        end_q, end_d;
  logic [1:0]  lives_q, lives_d;
`ifdef GAME_TIMER_EN
  logic [10:0] time_q, time_d;
`endif

  always_ff @(posedge clk40) begin
    if (!rst_n) begin
      phase_q   <= PH_START;
      start_q   <= 1'b0;
      restart_q <= 1'b0;
      end_q     <= 1'b0;
      lives_q   <= 2'(LIVES);
`ifdef GAME_TIMER_EN
      time_q    <= '0;
`endif
    end else begin
      phase_q   <= phase_d;
      start_q   <= start_d;
      restart_q <= restart_d;
      end_q     <= end_d;
      lives_q   <= lives_d;
`ifdef GAME_TIMER_EN
      time_q    <= time_d;
`endif
    end
  end

  always_comb begin
    phase_d   = phase_q;
    start_d   = 1'b0;
    restart_d = 1'b0;
    end_d     = 1'b0;
    lives_d   = lives_q;
`ifdef GAME_TIMER_EN
    time_d    = time_q;
`endif
    case (phase_q)
      PH_START: begin
        if (press) begin
          start_d = 1'b1;
          phase_d = PH_GAME;
          lives_d = 2'(LIVES);
`ifdef GAME_TIMER_EN
          time_d  = 11'(GAME_FRAMES);
`endif
        end
      end
      PH_GAME: begin
        // The cycle carrying start is the reload cycle; events then are dropped.
        if (!start_q) begin
          if (gf.hit && (lives_q != 2'd0)) begin
            lives_d = lives_q - 2'd1;
          end
`ifdef GAME_TIMER_EN
          if (tick_q && (time_q != 11'd0)) begin
            time_d = time_q - 11'd1;
          end
          // A coincident last hit and last tick still yield a single pulse.
          if ((gf.hit && (lives_q == 2'd1)) || (tick_q && (time_q == 11'd1))) begin
            end_d   = 1'b1;
            phase_d = PH_END;
          end
`else
          if (gf.hit && (lives_q == 2'd1)) begin
            end_d   = 1'b1;
            phase_d = PH_END;
          end
`endif
        end
      end
      PH_END: begin
        if (press) begin
          restart_d = 1'b1;
          phase_d   = PH_START;
          lives_d   = 2'(LIVES);
        end
      end
      default: begin
        phase_d = PH_START;
      end
    endcase
  end

  assign gf.start      = start_q;
  assign gf.restart    = restart_q;
  assign gf.end_game   = end_q;
  assign gf.phase      = phase_q;
  assign gf.lives_left = lives_q;
`ifdef GAME_TIMER_EN
  assign gf.time_left  = time_q;
`else
  assign gf.time_left  = 11'd0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - self-checking bench for game_flow_ctrl

module tb_game_flow_ctrl;

  localparam int DEB = 4;
  localparam int FR  = 3;
  localparam int LV  = 3;
`ifdef GAME_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic clk40 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk40 = ~clk40;

  game_flow_ctrl_if bus ();

  game_flow_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .GAME_FRAMES    (FR),
    .LIVES          (LV)
  ) dut (
    .clk40(clk40),
    .rst_n(rst_n),
    .gf   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: round state described by the game rules only.
  int m_phase = 0;   // 0 START, 1 GAME, 3 END
  int m_lives = LV;
  int m_time  = 0;
  int m_starts = 0, m_restarts = 0, m_ends = 0;

  // Pulse observations from the running design.
  int mon_start = 0, mon_restart = 0, mon_end = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk40) begin
    checks++;
    assert ($onehot0({bus.start, bus.restart, bus.end_game}) === 1'b1) else begin
      errors++;
      $error("FAIL pulse_exclusive observed=%b expected=onehot0",
             {bus.start, bus.restart, bus.end_game});
    end
    if (bus.start === 1'b1)    mon_start++;
    if (bus.restart === 1'b1)  mon_restart++;
    if (bus.end_game === 1'b1) mon_end++;
  end

  task automatic step();
    @(posedge clk40);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_phase"}, bus.phase, m_phase);
    chk({tag, "_lives"}, bus.lives_left, m_lives);
    chk({tag, "_time"}, bus.time_left, m_time);
  endtask

  // Full press: pulse expected DEB+3 cycles after the rise, only in START/END.
  task automatic press();
    bit exp_s, exp_r;
    exp_s = (m_phase == 0);
    exp_r = (m_phase == 3);
    bus.btn_in = 1'b1;
    repeat (DEB + 2) step();
    chk("press_early_start", bus.start, 1'b0);
    chk("press_early_restart", bus.restart, 1'b0);
    step();
    if (exp_s) begin
      m_phase = 1; m_lives = LV; m_time = TIMER ? FR : 0; m_starts++;
    end else if (exp_r) begin
      m_phase = 0; m_lives = LV; m_restarts++;
    end
    chk("press_start", bus.start, exp_s);
    chk("press_restart", bus.restart, exp_r);
    chk_state("press");
    step();
    chk("press_start_1cyc", bus.start, 1'b0);
    bus.btn_in = 1'b0;
    repeat (10) step();
    chk("start_count", mon_start, m_starts);
    chk("restart_count", mon_restart, m_restarts);
  endtask

  task automatic glitch();
    bus.btn_in = 1'b1;
    step();
    step();
    bus.btn_in = 1'b0;
    repeat (12) step();
    chk("glitch_starts", mon_start, m_starts);
    chk("glitch_restarts", mon_restart, m_restarts);
    chk("glitch_phase", bus.phase, m_phase);
  endtask

  task automatic model_apply(input bit h, input bit t, output bit ended);
    ended = 1'b0;
    if (m_phase == 1) begin
      if (h && m_lives > 0) m_lives--;
      if (TIMER && t && m_time > 0) m_time--;
      if (m_lives == 0 || (TIMER && m_time == 0)) begin
        m_phase = 3;
        m_ends++;
        ended = 1'b1;
      end
    end
  endtask

  // kind 0: hit; 1: vsync rise; 2: vsync rise then hit on the tick cycle
  task automatic do_event(input int kind);
    bit ended;
    case (kind)
      0: begin
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        model_apply(1'b1, 1'b0, ended);
      end
      1: begin
        bus.vsync_in = 1'b1;
        step();
        chk("tick_no_early_end", bus.end_game, 1'b0);
        step();
        model_apply(1'b0, 1'b1, ended);
      end
      default: begin
        bus.vsync_in = 1'b1;
        step();
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        model_apply(1'b1, 1'b1, ended);
      end
    endcase
    chk($sformatf("ev%0d_end", kind), bus.end_game, ended);
    chk_state($sformatf("ev%0d", kind));
    bus.vsync_in = 1'b0;
    repeat (4) step();
    chk("ev_phase_after", bus.phase, m_phase);
    chk("end_count", mon_end, m_ends);
  endtask

  initial begin
    bus.btn_in   = 1'b0;
    bus.vsync_in = 1'b0;
    bus.hit      = 1'b0;
    rst_n        = 1'b0;
    repeat (3) step();
    chk("rst_start", bus.start, 1'b0);
    chk("rst_restart", bus.restart, 1'b0);
    chk("rst_end", bus.end_game, 1'b0);
    chk_state("rst");
    rst_n = 1'b1;
    step();
    chk_state("rst_rel");

    // Start, then button activity inside GAME is inert.
    press();
    glitch();
    press();

    // Lives run out; a fourth hit lands in END and changes nothing.
    repeat (3) do_event(0);
    do_event(0);
    press();

    // Frame timer round; without the timer, finish the round with hits.
    press();
    repeat (3) do_event(1);
    while (m_phase == 1) do_event(0);
    press();

    // Last life and last frame consumed in the same cycle.
    press();
    do_event(0);
    do_event(0);
    if (TIMER) begin
      do_event(1);
      do_event(1);
    end
    do_event(2);
    press();

    // Randomized rounds against the rule model.
    repeat (4) begin
      if (m_phase == 3) press();
      if (m_phase == 0) press();
      repeat (6) begin
        repeat ($urandom_range(0, 5)) step();
        do_event(int'($urandom_range(0, 2)));
      end
    end

    // Reset in the middle of a round.
    if (m_phase == 3) press();
    if (m_phase == 0) press();
    do_event(0);
    rst_n = 1'b0;
    step();
    m_phase = 0; m_lives = LV; m_time = 0;
    chk("midrst_start", bus.start, 1'b0);
    chk("midrst_end", bus.end_game, 1'b0);
    chk_state("midrst");
    rst_n = 1'b1;
    step();
    chk("midrst_rel_start", bus.start, 1'b0);
    chk_state("midrst_rel");

    // Button held through reset yields exactly one start after release.
    bus.btn_in = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    press();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Game-flow controller sitting directly upstream of the screen multiplexer: it turns the raw player button, the game-frame vsync and the game-logic hit strobe into the one-cycle `start`, `restart` and `end_game` pulses that drive screen selection. It runs its own START/GAME/END phase tracker, which moves on the same pulses it emits and so stays in lock-step with the multiplexer. It also publishes remaining lives and remaining game time for the HUD renderer.

## Interface
- `DEBOUNCE_CYCLES`, 400000: consecutive stable cycles required to accept a button level (10 ms at 40 MHz); minimum 2.
- `GAME_FRAMES`, 1800: frames per game round (30 s at 60 Hz); 1..2047.
- `LIVES`, 3: lives per round; 1..3.
- `clk40  in  1`  system clock, 40 MHz.
- `rst_n  in  1`  reset, synchronous, active-low.
- `btn_in  in  1`  raw asynchronous player button, active-high.
- `vsync_in  in  1`  game-path vsync, clk40 domain.
- `hit  in  1`  one-cycle strobe from game logic: player lost a life.
- `start  out  1`  one-cycle pulse: leave START.
- `restart  out  1`  one-cycle pulse: leave END.
- `end_game  out  1`  one-cycle pulse: leave GAME.
- `phase  out  2`  current phase: START=2'b00, GAME=2'b01, END=2'b11.
- `lives_left  out  2`  remaining lives.
- `time_left  out  11`  remaining frames in the round.

## Operation
- Button path:
  - 2-flop synchronizer, then debouncer.
  - The debounce counter clears whenever the synchronized level equals `stable`; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1, `stable` takes the synchronized level and the counter clears.
  - `press` is the 0->1 transition of `stable`. Release edges generate nothing.
- Phase FSM:
  - START: `press` -> pulse `start`, go to GAME, load `lives_left`=LIVES and `time_left`=GAME_FRAMES.
  - GAME: `press` is ignored. An end condition -> pulse `end_game`, go to END.
  - END: `press` -> pulse `restart`, go to START, load `lives_left`=LIVES.
  - Unused encoding 2'b10 -> START next cycle, no pulse.
- `vsync_in` rising edge (registered compare against previous sample) = frame tick. Ticks and hits are counted only in GAME.
- Time end condition:
  - Each frame tick decrements `time_left`.
  - A tick while `time_left`==1 sets it to 0 and fires `end_game`.
- Lives end condition:
  - Each `hit` decrements `lives_left`.
  - A `hit` while `lives_left`==1 sets it to 0 and fires `end_game`.
- Counters saturate at 0 and never wrap.
- Simultaneous tick and hit: both counters update, and at most one `end_game` pulse fires.
- `hit` or tick coinciding with the `start` cycle: ignored, because the counters are reloading.
- At most one of `start`, `restart`, `end_game` is high in any cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `start`=`restart`=`end_game`=0, `phase`=START, `lives_left`=LIVES, `time_left`=0.
  - Synchronizer, `stable` and counter all 0.
  - Previous-vsync register 0.
- Reset mid-round aborts it immediately; the next cycle is in START with no pulse.
- A button held from reset produces one `press` after debounce.
- `btn_in` rise held high -> `start`/`restart` high exactly DEBOUNCE_CYCLES+3 cycles later, for 1 cycle.
- Glitches shorter than DEBOUNCE_CYCLES-1 synchronized cycles are rejected.
- `phase` changes in the same cycle the pulse is high.
- End-condition latency:
  - `hit` in cycle N -> `lives_left` updated and `end_game` (if applicable) in cycle N+1.
  - `vsync_in` rise sampled in cycle N -> `time_left` updated and `end_game` in cycle N+2.

## Configuration
- `GAME_TIMER_EN` defined:
  - Frame-tick timer is built; the time end condition is active.
- `GAME_TIMER_EN` undefined:
  - Timer logic and vsync edge detector are removed.
  - `time_left` is tied to 0; only lives end the round.
  - `vsync_in` is unused.

## Test plan
- Reset, bench params DEBOUNCE_CYCLES=4, GAME_FRAMES=3, LIVES=3 -> all pulses 0, `phase`=00, `lives_left`=3, `time_left`=0. Hold `btn_in` high -> `start` 1 cycle at 7 cycles after the rise, `phase`=01, `time_left`=3.
- In GAME, 2-cycle `btn_in` glitch -> no pulse. Full press -> no pulse, `phase` stays 01.
- In GAME, 3 `hit` strobes 10 cycles apart -> `lives_left` 2,1,0. `end_game` fires 1 cycle after the third hit, `phase`=11. A 4th hit leaves `lives_left`=0.
- In GAME, 3 vsync rises -> `time_left` 2,1,0. `end_game` fires 2 cycles after the third rise. With `GAME_TIMER_EN` undefined, the same stimulus gives no `end_game` and `time_left`=0.
- `lives_left`=1 and `time_left`=1, `hit` in the cycle the tick is registered -> exactly one `end_game` pulse, both counters 0.
- In END, press -> `restart` pulse, `phase`=00, `lives_left`=3. Apply `rst_n`=0 for 1 cycle mid-GAME -> `phase`=00, no pulses, counters at reset values.
